// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from HS/VS/DE and
// measures per-frame timing, a pixel checksum, lock and consistency status.
module vga_rx_monitor #(
   parameter int unsigned PIX_WIDTH = 12,
   parameter logic        HS_POL    = 1'b0,
   parameter logic        VS_POL    = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 vga_hs_i,
   input  logic                 vga_vs_i,
   input  logic                 vga_de_i,
   input  logic [7:0]           vga_r_i,
   input  logic [7:0]           vga_g_i,
   input  logic [7:0]           vga_b_i,
   output logic                 pix_valid_o,
   output logic [PIX_WIDTH-1:0] pix_x_o,
   output logic [PIX_WIDTH-1:0] pix_y_o,
   output logic [23:0]          pix_data_o,
   output logic                 frame_done_o,
   output logic [PIX_WIDTH-1:0] h_total_o,
   output logic [PIX_WIDTH-1:0] h_disp_o,
   output logic [PIX_WIDTH-1:0] v_total_o,
   output logic [PIX_WIDTH-1:0] v_disp_o,
   output logic [31:0]          frame_sum_o,
   output logic                 locked_o,
   output logic                 err_o
);

   typedef logic [PIX_WIDTH-1:0] cnt_t;
   localparam cnt_t CNT_MAX = '1;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == CNT_MAX) ? v : v + cnt_t'(1);
   endfunction

   logic        hs_p0, vs_p0, vld_p0;
   logic [23:0] rgb_p0;
   logic        hs_act_p1, vs_act_p1, vld_p1;
   logic [23:0] rgb_p1;
   logic        hs_act_p2, vs_act_p2, vld_p2;

   cnt_t        h_cnt, x_cnt, y_cnt, h_total_run, ref_len, run_cnt, line_cnt;
   cnt_t        prev_ht, prev_hd, prev_vt, prev_vd;
   logic        ref_vld, err_flag, seen_vs, prev_vld;
   logic [31:0] sum;

   logic        line_edge, frame_edge, de_rise, de_fall, len_bad, de_bad, err_cl, tuple_same;
   cnt_t        run_len, h_tot_cap, x_nxt, y_nxt, runs_cl, ref_len_cl, h_tot_cl;
   logic [31:0] sum_cl;

   // Stage 0: register the raw interface
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hs_p0  <= ~HS_POL;
         vs_p0  <= ~VS_POL;
         vld_p0 <= 1'b0;
      end else begin
         hs_p0  <= vga_hs_i;
         vs_p0  <= vga_vs_i;
         vld_p0 <= vga_de_i;
      end
   end

   // Stage 1: sync-active decode; stage 2 holds the previous sample for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hs_act_p1 <= 1'b0;
         vs_act_p1 <= 1'b0;
         vld_p1    <= 1'b0;
         hs_act_p2 <= 1'b0;
         vs_act_p2 <= 1'b0;
         vld_p2    <= 1'b0;
      end else begin
         hs_act_p1 <= (hs_p0 == HS_POL);
         vs_act_p1 <= (vs_p0 == VS_POL);
         vld_p1    <= vld_p0;
         hs_act_p2 <= hs_act_p1;
         vs_act_p2 <= vs_act_p1;
         vld_p2    <= vld_p1;
      end
   end

   always_ff @(posedge clk_i) begin
      rgb_p0 <= {vga_r_i, vga_g_i, vga_b_i};
      rgb_p1 <= rgb_p0;
   end

   // "_cl" values are what the frame being closed would report this cycle,
   // so a run ending on the frame edge still counts toward the old frame.
   always_comb begin
      line_edge  = hs_act_p1 & ~hs_act_p2;
      frame_edge = vs_act_p1 & ~vs_act_p2;
      de_rise    = vld_p1 & ~vld_p2;
      de_fall    = ~vld_p1 & vld_p2;
      run_len    = sat_inc(x_cnt);
      h_tot_cap  = sat_inc(h_cnt);
      x_nxt      = de_rise ? '0 : (vld_p1 ? sat_inc(x_cnt) : x_cnt);
      y_nxt      = frame_edge ? '0 : (de_fall ? sat_inc(y_cnt) : y_cnt);
      runs_cl    = de_fall ? sat_inc(run_cnt) : run_cnt;
      ref_len_cl = (de_fall && !ref_vld) ? run_len : ref_len;
      len_bad    = de_fall && ref_vld && (run_len != ref_len);
      de_bad     = vld_p1 && (hs_act_p1 || vs_act_p1);
      err_cl     = err_flag | len_bad | de_bad;
      sum_cl     = vld_p1 ? sum + {8'd0, rgb_p1} : sum;
      h_tot_cl   = line_edge ? h_tot_cap : h_total_run;
      tuple_same = (h_tot_cl == prev_ht) && (ref_len_cl == prev_hd) &&
                   (line_cnt == prev_vt) && (runs_cl == prev_vd);
   end

   // Stage 2: counters, accumulators and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h_cnt        <= '0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         h_total_run  <= '0;
         ref_len      <= '0;
         ref_vld      <= 1'b0;
         run_cnt      <= '0;
         line_cnt     <= '0;
         err_flag     <= 1'b0;
         sum          <= '0;
         seen_vs      <= 1'b0;
         prev_vld     <= 1'b0;
         prev_ht      <= '0;
         prev_hd      <= '0;
         prev_vt      <= '0;
         prev_vd      <= '0;
         pix_valid_o  <= 1'b0;
         pix_x_o      <= '0;
         pix_y_o      <= '0;
         pix_data_o   <= '0;
         frame_done_o <= 1'b0;
         h_total_o    <= '0;
         h_disp_o     <= '0;
         v_total_o    <= '0;
         v_disp_o     <= '0;
         frame_sum_o  <= '0;
         locked_o     <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         h_cnt        <= line_edge ? '0 : sat_inc(h_cnt);
         x_cnt        <= x_nxt;
         y_cnt        <= y_nxt;
         pix_valid_o  <= vld_p1;
         pix_x_o      <= x_nxt;
         pix_y_o      <= y_nxt;
         pix_data_o   <= rgb_p1;
         frame_done_o <= 1'b0;
         if (frame_edge) begin
            seen_vs <= 1'b1;
            // The first edge after reset closes a partial frame: sync only.
            if (seen_vs) begin
               frame_done_o <= 1'b1;
               h_total_o    <= h_tot_cl;
               h_disp_o     <= ref_len_cl;
               v_total_o    <= line_cnt;
               v_disp_o     <= runs_cl;
               frame_sum_o  <= sum_cl;
               err_o        <= err_cl;
               locked_o     <= prev_vld && tuple_same && !err_cl;
               prev_vld     <= 1'b1;
               prev_ht      <= h_tot_cl;
               prev_hd      <= ref_len_cl;
               prev_vt      <= line_cnt;
               prev_vd      <= runs_cl;
            end
            h_total_run <= line_edge ? h_tot_cap : '0;
            line_cnt    <= line_edge ? cnt_t'(1) : '0;
            ref_len     <= '0;
            ref_vld     <= 1'b0;
            run_cnt     <= '0;
            err_flag    <= 1'b0;
            sum         <= '0;
         end else begin
            if (line_edge) begin
               h_total_run <= h_tot_cap;
               line_cnt    <= sat_inc(line_cnt);
            end
            if (de_fall) begin
               run_cnt <= runs_cl;
               if (!ref_vld) begin
                  ref_len <= run_len;
                  ref_vld <= 1'b1;
               end
            end
            err_flag <= err_cl;
            sum      <= sum_cl;
         end
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor: directed 16x8 (and 20x8) frames,
// inverted-polarity and narrow-counter instances share the same stimulus.
module tb_vga_rx_monitor;

   typedef struct {
      int          t;
      int          ht;
      int          hd;
      int          vt;
      int          vd;
      logic [31:0] sum;
      logic        err;
      logic        lock;
   } frame_t;

   typedef struct {
      int          t;
      int          x;
      int          y;
      logic [23:0] d;
   } pix_t;

   logic clk = 1'b0;
   logic rst, hs, vs, de;
   logic [7:0] r, g, b;
   logic hs_n, vs_n;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int yexp = 0;

   frame_t fq[$];
   pix_t   pq[$];
   frame_t fe;
   pix_t   pe;

   logic        pv, done, lk, er;
   logic [11:0] px, py, ht, hd, vt, vd;
   logic [23:0] pd;
   logic [31:0] fs;

   logic        p_pv, p_done, p_lk, p_er;
   logic [11:0] p_px, p_py, p_ht, p_hd, p_vt, p_vd;
   logic [23:0] p_pd;
   logic [31:0] p_fs;

   logic        s_pv, s_done, s_lk, s_er;
   logic [3:0]  s_px, s_py, s_ht, s_hd, s_vt, s_vd;
   logic [23:0] s_pd;
   logic [31:0] s_fs;

   assign hs_n = ~hs;
   assign vs_n = ~vs;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_rx_monitor #(.PIX_WIDTH(12), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
      .clk_i(clk), .rst_i(rst), .vga_hs_i(hs), .vga_vs_i(vs), .vga_de_i(de),
      .vga_r_i(r), .vga_g_i(g), .vga_b_i(b),
      .pix_valid_o(pv), .pix_x_o(px), .pix_y_o(py), .pix_data_o(pd),
      .frame_done_o(done), .h_total_o(ht), .h_disp_o(hd), .v_total_o(vt),
      .v_disp_o(vd), .frame_sum_o(fs), .locked_o(lk), .err_o(er));

   vga_rx_monitor #(.PIX_WIDTH(12), .HS_POL(1'b1), .VS_POL(1'b1)) dut_pol (
      .clk_i(clk), .rst_i(rst), .vga_hs_i(hs_n), .vga_vs_i(vs_n), .vga_de_i(de),
      .vga_r_i(r), .vga_g_i(g), .vga_b_i(b),
      .pix_valid_o(p_pv), .pix_x_o(p_px), .pix_y_o(p_py), .pix_data_o(p_pd),
      .frame_done_o(p_done), .h_total_o(p_ht), .h_disp_o(p_hd), .v_total_o(p_vt),
      .v_disp_o(p_vd), .frame_sum_o(p_fs), .locked_o(p_lk), .err_o(p_er));

   vga_rx_monitor #(.PIX_WIDTH(4), .HS_POL(1'b0), .VS_POL(1'b0)) dut_sat (
      .clk_i(clk), .rst_i(rst), .vga_hs_i(hs), .vga_vs_i(vs), .vga_de_i(de),
      .vga_r_i(r), .vga_g_i(g), .vga_b_i(b),
      .pix_valid_o(s_pv), .pix_x_o(s_px), .pix_y_o(s_py), .pix_data_o(s_pd),
      .frame_done_o(s_done), .h_total_o(s_ht), .h_disp_o(s_hd), .v_total_o(s_vt),
      .v_disp_o(s_vd), .frame_sum_o(s_fs), .locked_o(s_lk), .err_o(s_er));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pix_valid"}, pv, 0);
      chk({tag, "_pix_x"}, px, 0);
      chk({tag, "_pix_y"}, py, 0);
      chk({tag, "_pix_data"}, pd, 0);
      chk({tag, "_frame_done"}, done, 0);
      chk({tag, "_h_total"}, ht, 0);
      chk({tag, "_h_disp"}, hd, 0);
      chk({tag, "_v_total"}, vt, 0);
      chk({tag, "_v_disp"}, vd, 0);
      chk({tag, "_frame_sum"}, fs, 0);
      chk({tag, "_locked"}, lk, 0);
      chk({tag, "_err"}, er, 0);
   endtask

   // One 8-line frame: lines 0-3 active, VS on lines 5-6, HS on cycles 10-12.
   task automatic drive_frame(input int hlen, input bit glitch, input bit rst_mid,
                              input bit exp_en, input int e_ht, input int e_hd,
                              input logic [31:0] e_sum, input bit e_err, input bit e_lock);
      frame_t f;
      pix_t   p;
      for (int l = 0; l < 8; l++) begin
         for (int c = 0; c < hlen; c++) begin
            @(posedge clk);
            #1;
            if (rst_mid && l == 2 && c == 13) begin
               check_zero("midrst");
               yexp = 0;
            end
            rst = rst_mid && l == 2 && c == 12;
            de  = (l < 4) && (c < 8) && !(glitch && l == 0 && c == 7);
            hs  = !(c >= 10 && c <= 12);
            vs  = !(l == 5 || l == 6);
            r   = 8'd0;
            g   = l[7:0];
            b   = c[7:0];
            if (de) begin
               p.t = cyc + 3;
               p.x = c;
               p.y = yexp;
               p.d = {8'd0, l[7:0], c[7:0]};
               pq.push_back(p);
            end
            if (l < 4 && c == 8) yexp++;
            if (l == 5 && c == 0) begin
               yexp = 0;
               if (exp_en) begin
                  f.t    = cyc + 3;
                  f.ht   = e_ht;
                  f.hd   = e_hd;
                  f.vt   = 8;
                  f.vd   = 4;
                  f.sum  = e_sum;
                  f.err  = e_err;
                  f.lock = e_lock;
                  fq.push_back(f);
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (fq.size() == 0) chk("frame_done_unexpected", done, 1'b0);
         else begin
            fe = fq.pop_front();
            chk("done_time", cyc, fe.t);
            chk("h_total", ht, fe.ht);
            chk("h_disp", hd, fe.hd);
            chk("v_total", vt, fe.vt);
            chk("v_disp", vd, fe.vd);
            chk("frame_sum", fs, fe.sum);
            chk("err", er, fe.err);
            chk("locked", lk, fe.lock);
            chk("pol_done", p_done, 1'b1);
            chk("pol_h_total", p_ht, fe.ht);
            chk("pol_h_disp", p_hd, fe.hd);
            chk("pol_v_total", p_vt, fe.vt);
            chk("pol_v_disp", p_vd, fe.vd);
            chk("pol_frame_sum", p_fs, fe.sum);
            chk("pol_err", p_er, fe.err);
            chk("pol_locked", p_lk, fe.lock);
         end
      end else if (p_done) chk("pol_done_unexpected", p_done, 1'b0);
      if (fq.size() > 0 && cyc > fq[0].t) begin
         chk("frame_done_missing", done, 1'b1);
         fe = fq.pop_front();
      end

      if (pv) begin
         if (pq.size() == 0) chk("pix_valid_unexpected", pv, 1'b0);
         else begin
            pe = pq.pop_front();
            chk("pix_time", cyc, pe.t);
            chk("pix_x", px, pe.x);
            chk("pix_y", py, pe.y);
            chk("pix_data", pd, pe.d);
         end
      end
      if (pq.size() > 0 && cyc > pq[0].t) begin
         chk("pix_valid_missing", pv, 1'b1);
         pe = pq.pop_front();
      end
   end

   initial begin
      rst = 1'b1;
      hs  = 1'b1;
      vs  = 1'b1;
      de  = 1'b0;
      r   = 8'd0;
      g   = 8'd0;
      b   = 8'd0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check_zero("reset");

      drive_frame(16, 0, 0, 0, 0, 0, 32'd0, 0, 0);      // partial frame: sync only
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 0);
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 1);
      drive_frame(16, 1, 0, 1, 16, 7, 32'd12393, 1, 0); // first run cut to 7 pixels
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 0);
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 1);
      drive_frame(16, 0, 1, 0, 0, 0, 32'd0, 0, 0);      // reset in line 2, resync edge
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 0);
      drive_frame(16, 0, 0, 1, 16, 8, 32'd12400, 0, 1);
      drive_frame(20, 0, 0, 1, 20, 8, 32'd12400, 0, 0);
      drive_frame(20, 0, 0, 1, 20, 8, 32'd12400, 0, 1);

      repeat (10) @(posedge clk);
      #1;
      chk("frames_pending", fq.size(), 0);
      chk("pixels_pending", pq.size(), 0);
      chk("sat_h_total", s_ht, 15);
      chk("sat_h_disp", s_hd, 8);
      chk("sat_v_total", s_vt, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
